led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
Parametrised LED pattern engine, successor to the fixed 8-LED ping-pong shifter on PMOD0. Drives N LEDs with a runtime-programmable step rate. Four selectable modes: rotate-left, rotate-right, bounce, bar-fill. Adds enable/pause, a step strobe for other blocks, and configurable output polarity. Sits between the board clock and any PMOD or on-board LED bank.

Parameters:
N_LEDS, 8, number of LEDs driven; legal range 2..32
DIV_W, 32, width of step divider input and internal prescaler counter
ACTIVE_LOW, 1, 1 = LED lit when output bit is 0 (PMOD0 LEDs); 0 = lit when 1

Ports:
clk  in  1  system clock (50 MHz on board)
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = prescaler runs and pattern advances; 0 = freeze
mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 bar-fill
step_div  in  DIV_W  clocks per step; 0 treated as 1; 25_000_000 gives 2 steps/s at 50 MHz
led_output  out  N_LEDS  LED drive, polarity per ACTIVE_LOW
step_pulse  out  1  one-cycle strobe on each pattern step

Behaviour:
- Internal state:
  - pat[N_LEDS-1:0], active-high, 1 = lit
  - dir: 0 = toward MSB, 1 = toward LSB
  - cnt[DIV_W-1:0], prescaler count
  - mode_q[1:0], mode applied at the last step
- led_output = ACTIVE_LOW ? ~pat : pat. Purely an inversion of flop outputs; no other logic on the output path.
- Reset (rst_n=0, asynchronous): pat=1 (bit0 only), dir=0, cnt=0, mode_q=00, step_pulse=0. With defaults, led_output=8'hFE.
- Prescaler, only while enable=1:
  - tick when cnt >= max(step_div,1)-1; on tick cnt<=0, otherwise cnt<=cnt+1.
  - The >= compare means lowering step_div mid-count causes a tick on the next cycle, never a 2^DIV_W wrap.
- enable=0: cnt, pat, dir and mode_q all hold; step_pulse=0. On re-enable, counting resumes from the held cnt.
- step_pulse is registered, high for exactly the cycle after the tick, aligned with the new pat value. step_div=1 with enable held high gives step_pulse continuously high.
- On tick, if mode != mode_q: pat<=1, dir<=0, mode_q<=mode. This tick is consumed by the reload (no shift). A mode change is therefore visible only at a step boundary.
- On tick, if mode == mode_q:
  - 00 rotate-left: pat <= {pat[N-2:0], pat[N-1]}
  - 01 rotate-right: pat <= {pat[0], pat[N-1:1]}
  - 10 bounce:
    - if dir=0 and pat[N-1]=1: dir<=1 and pat<=pat>>1 in the same tick.
    - if dir=1 and pat[0]=1: dir<=0 and pat<=pat<<1.
    - otherwise shift one position in direction dir.
    - No double dwell at the ends; period = 2*N_LEDS-2 steps.
  - 11 bar-fill: pat <= (pat == all-ones) ? 0 : {pat[N-2:0],1'b1}. Period = N_LEDS+1 steps; sequence includes all-off.
- Direction decision uses the registered pat, not the value being written in the same cycle.
- Simultaneous tick and mode change: the reload has priority over the shift.
- Reset mid-step: immediate return to the reset state; any partial prescaler count is discarded.

Test Plan:
- Reset, defaults, step_div=4, mode=00, enable=1 -> led_output FE, FD, FB, F7, EF, DF, BF, 7F, FE; transitions every 4 clocks; step_pulse high 1 cycle per step.
- N_LEDS=4, ACTIVE_LOW=0, mode=10, step_div=1 -> pat 0001,0010,0100,1000,0100,0010,0001,0010 on consecutive cycles; no repeated end value.
- N_LEDS=4, ACTIVE_LOW=0, mode=11, step_div=2 -> 0001,0011,0111,1111,0000,0001 every 2 clocks.
- Mode 00 running at pat=0x08, switch mode to 01 -> at next tick pat reloads 0x01 with no shift; next tick pat=0x80.
- enable=0 for 10 cycles at cnt=2, step_div=5 -> led_output and step_pulse frozen; after re-enable, the next step occurs exactly 3 clocks later.
- step_div 100 -> 3 when cnt=50 -> tick on next cycle. step_div=0 -> step every clock. Assert rst_n low mid-count -> led_output=FE within the same cycle (asynchronous).

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: rotate-left, rotate-right, bounce and bar-fill
// over N_LEDS outputs, advanced by a programmable prescaler.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     1 = prescaler runs and pattern advances, 0 = freeze
//   mode       00 rotate-left, 01 rotate-right, 10 bounce, 11 bar-fill
//   step_div   clocks per step (0 behaves as 1)
//   led_output LED drive, inverted when ACTIVE_LOW is set
//   step_pulse one-cycle strobe aligned with each new pattern value
module led_pattern_sequencer #(
    parameter int N_LEDS     = 8,
    parameter int DIV_W      = 32,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    output logic [N_LEDS-1:0] led_output,
    output logic              step_pulse
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic [N_LEDS-1:0] PAT_RST = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] PAT_ALL = '1;

    logic [N_LEDS-1:0] pat_q, pat_d, pat_shift;
    dir_e              dir_q, dir_d, dir_shift;
    mode_e             mode_q, mode_d, mode_in;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_last;
    logic              pulse_q;
    logic              tick;

    assign mode_in = mode_e'(mode);

    // Last count value of a step; step_div of 0 behaves as 1.
    assign div_last = (step_div == '0) ? '0
                                       : step_div - DIV_W'(1);

    // >= rather than == so a lowered divider ticks at once
    // instead of wrapping the whole counter range.
    assign tick = enable && (cnt_q >= div_last);

    // One step of the currently applied mode, from registered state.
    always_comb begin
        pat_shift = pat_q;
        dir_shift = dir_q;
        unique case (mode_q)
            MODE_ROTL: begin
                pat_shift = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            end
            MODE_ROTR: begin
                pat_shift = {pat_q[0], pat_q[N_LEDS-1:1]};
            end
            MODE_BOUNCE: begin
                // Turn around and move in the same step: no dwell
                // at either end.
                if (dir_q == DIR_UP) begin
                    if (pat_q[N_LEDS-1]) begin
                        dir_shift = DIR_DN;
                        pat_shift = pat_q >> 1;
                    end else begin
                        pat_shift = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        dir_shift = DIR_UP;
                        pat_shift = pat_q << 1;
                    end else begin
                        pat_shift = pat_q >> 1;
                    end
                end
            end
            MODE_BAR: begin
                pat_shift = (pat_q == PAT_ALL) ? '0
                          : {pat_q[N_LEDS-2:0], 1'b1};
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
        if (tick) begin
            // A new mode consumes the step as a reload.
            if (mode_in != mode_q) begin
                pat_d  = PAT_RST;
                dir_d  = DIR_UP;
                mode_d = mode_in;
            end else begin
                pat_d = pat_shift;
                dir_d = dir_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= PAT_RST;
            dir_q   <= DIR_UP;
            mode_q  <= MODE_ROTL;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pulse_q <= tick;
        end
    end

    assign led_output = ACTIVE_LOW ? ~pat_q : pat_q;
    assign step_pulse = pulse_q;

endmodule
